// File: rtl/btn_conditioner.sv
// Push-button conditioner: two-flop synchronizer, debounce FSM and press/release/long-press pulses.
// Optional long-press detection is enabled by defining BTN_CONDITIONER_LONGPRESS_EN.
module btn_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 120000,
  parameter int unsigned LONG_CYCLES     = 24000000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic btn_level,
  output logic press,
  output logic rel_pulse,
  output logic long_pulse
);

  localparam logic [1:0] IDLE         = 2'd0;
  localparam logic [1:0] PRESS_WAIT   = 2'd1;
  localparam logic [1:0] PRESSED      = 2'd2;
  localparam logic [1:0] RELEASE_WAIT = 2'd3;

  localparam logic [23:0] DEB_LAST = 24'(DEBOUNCE_CYCLES - 32'd1);

  logic        btn_meta;
  logic        btn_sync;
  logic [1:0]  state;
  logic [23:0] cnt;

  // Two-flop synchronizer; btn_sync is the only view of the button the FSM has
  always_ff @(posedge clk) begin
    if (reset) begin
      btn_meta <= 1'b0;
      btn_sync <= 1'b0;
    end else begin
      btn_meta <= btn_raw;
      btn_sync <= btn_meta;
    end
  end

  // Debounce FSM with registered one-cycle press/release pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= 24'd0;
      btn_level <= 1'b0;
      press     <= 1'b0;
      rel_pulse <= 1'b0;
    end else begin
      press     <= 1'b0;
      rel_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (btn_sync) begin
            state <= PRESS_WAIT;
            cnt   <= 24'd0;
          end else begin
            state <= IDLE;
          end
        end
        PRESS_WAIT: begin
          if (!btn_sync) begin
            state <= IDLE;
          end else if (cnt == DEB_LAST) begin
            state     <= PRESSED;
            press     <= 1'b1;
            btn_level <= 1'b1;
          end else begin
            cnt <= cnt + 24'd1;
          end
        end
        PRESSED: begin
          if (!btn_sync) begin
            state <= RELEASE_WAIT;
            cnt   <= 24'd0;
          end else begin
            state <= PRESSED;
          end
        end
        RELEASE_WAIT: begin
          if (btn_sync) begin
            state <= PRESSED;
          end else if (cnt == DEB_LAST) begin
            state     <= IDLE;
            rel_pulse <= 1'b1;
            btn_level <= 1'b0;
          end else begin
            cnt <= cnt + 24'd1;
          end
        end
        default: begin
          state     <= IDLE;
          cnt       <= 24'd0;
          btn_level <= 1'b0;
        end
      endcase
    end
  end

`ifdef BTN_CONDITIONER_LONGPRESS_EN
  localparam logic [24:0] LONG_LAST = 25'(LONG_CYCLES - 32'd1);
  localparam logic [24:0] LONG_DONE = 25'(LONG_CYCLES);

  logic [24:0] hold;
  logic        press_accept;

  assign press_accept = (state == PRESS_WAIT) && btn_sync && (cnt == DEB_LAST);

  // Hold counter: restarts on acceptance, counts PRESSED cycles, parks past the target after firing
  always_ff @(posedge clk) begin
    if (reset) begin
      hold       <= 25'd0;
      long_pulse <= 1'b0;
    end else begin
      long_pulse <= 1'b0;
      if (press_accept) begin
        hold <= 25'd0;
      end else if (state == PRESSED) begin
        if (hold == LONG_LAST) begin
          long_pulse <= 1'b1;
          hold       <= LONG_DONE;
        end else if (hold < LONG_LAST) begin
          hold <= hold + 25'd1;
        end else begin
          hold <= hold;
        end
      end else begin
        hold <= hold;
      end
    end
  end
`else
  // Never true within the legal LONG_CYCLES range, so this is a constant 0
  assign long_pulse = (LONG_CYCLES == 32'd0);
`endif

endmodule

// File: doc/btn_conditioner.md
BTN_CONDITIONER -- requirements
Module: btn_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 120000, meaning: number of consecutive stable synchronized samples needed to accept a level change (10 ms at 12 MHz); legal range 2 to 2^24-1.
REQ-002 Parameter LONG_CYCLES, default 24000000, meaning: number of held cycles after acceptance before the long-press pulse (2 s at 12 MHz); legal range 2 to 2^25-1.
REQ-003 clk  input  1  system clock, 12 MHz undivided; all logic SHALL be clocked on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 btn_raw  input  1  asynchronous, bouncing push-button level, active high.
REQ-006 btn_level  output  1  debounced button level.
REQ-007 press  output  1  one-cycle pulse when a press is accepted; drives the countdown controller's start input.
REQ-008 rel_pulse  output  1  one-cycle pulse when a release is accepted.
REQ-009 long_pulse  output  1  one-cycle pulse after a continuous hold; drives the controller's abort/reset input.

Function
REQ-010 btn_raw SHALL pass through a two-flop synchronizer; the second stage, btn_sync, SHALL be the only signal the FSM reads.
REQ-011 The FSM SHALL have the states IDLE, PRESS_WAIT, PRESSED and RELEASE_WAIT, plus a debounce counter cnt of at least 24 bits.
REQ-012 IDLE: if btn_sync=1, go to PRESS_WAIT with cnt<=0; otherwise stay.
REQ-013 PRESS_WAIT: if btn_sync=0, return to IDLE; else if cnt==DEBOUNCE_CYCLES-1, go to PRESSED, assert press and set btn_level<=1; else cnt<=cnt+1.
REQ-014 PRESSED: if btn_sync=0, go to RELEASE_WAIT with cnt<=0; otherwise stay.
REQ-015 RELEASE_WAIT: if btn_sync=1, return to PRESSED with no pulse and btn_level unchanged; else if cnt==DEBOUNCE_CYCLES-1, go to IDLE, assert rel_pulse and set btn_level<=0; else cnt<=cnt+1.
REQ-016 Latency: with btn_raw held high, press SHALL be high in the cycle after the (DEBOUNCE_CYCLES+3)th rising edge, counting the first edge that samples btn_raw high as edge 1. The release path SHALL have the same latency.
REQ-017 press, rel_pulse and long_pulse SHALL be registered, SHALL each be high for exactly one cycle per event, and SHALL never be high in the same cycle.
REQ-018 A glitch shorter than DEBOUNCE_CYCLES synchronized samples SHALL produce no pulse and no btn_level change, and SHALL restart the count from 0.
REQ-019 If the state register holds an unused encoding, the FSM SHALL go to IDLE on the next edge with all outputs 0.

Reset
REQ-020 While reset=1 at a rising edge, the FSM SHALL go to IDLE and all counters, synchronizer flops, btn_level, press, rel_pulse and long_pulse SHALL go to 0; reset takes priority over every transition.
REQ-021 Reset mid-press SHALL cancel any pending pulse; a button still held after reset deasserts SHALL require the full REQ-016 latency before press.

Configuration
REQ-022 Macro BTN_CONDITIONER_LONGPRESS_EN defined: a hold counter of at least 25 bits SHALL be cleared on the PRESS_WAIT-to-PRESSED transition.
- It SHALL increment on each cycle spent in PRESSED and SHALL hold its value in RELEASE_WAIT.
- When it equals LONG_CYCLES-1 in PRESSED, long_pulse SHALL assert on the next edge.
- long_pulse SHALL fire at most once per accepted press; the counter then saturates.
REQ-023 Macro undefined: long_pulse SHALL be constant 0 and no hold counter SHALL be synthesized; all other behaviour SHALL be identical.

Verification (DEBOUNCE_CYCLES=4, LONG_CYCLES=10, macro defined unless noted)
REQ-024 Clean press: btn_raw 0->1 sampled at edge 1 and held -> press high only after edge 7; btn_level=1 from edge 7 onward; no other pulse.
REQ-025 Bounce rejection: btn_raw high 3 cycles, low 1 cycle, then held high -> no press until 7 edges after the final rising sample; exactly one press.
REQ-026 Long press: hold btn_raw -> press after edge 7, long_pulse after edge 17; holding 30 more cycles -> no further long_pulse. Release -> one rel_pulse 7 edges after the first low sample.
REQ-027 Release glitch: while PRESSED, btn_raw low 2 cycles then high -> no rel_pulse; btn_level stays 1; long_pulse timing shifted only by the cycles spent in RELEASE_WAIT.
REQ-028 Reset mid-operation: assert reset at edge 6 of a press, then release reset with btn_raw still high -> all outputs 0 during reset; press reappears 7 edges after the first post-reset edge.
REQ-029 Macro undefined: repeat REQ-026 -> long_pulse stays 0 throughout; press and rel_pulse timing unchanged.
